// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   FETCH_RESET_VECTOR : default PC of the first fetch after reset
//   fetch_entry_t      : one buffered instruction word with the PC it was fetched from
//   word_align()       : clears the byte-offset bits of an address
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for both the instruction buffer and the pending-PC queue.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, wdata_i  : write an entry (ignored when full unless a pop frees a slot)
//   pop_i            : drop the head entry (ignored when empty)
//   flush_i          : discard all entries; overrides push and pop in the same cycle
//   rdata_o          : head entry straight from storage registers
//   count_o          : number of valid entries
//   full_o, empty_o  : occupancy flags
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic [31:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    T              mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_last;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(Depth));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // When empty, keep showing the most recently popped slot so the output holds still.
    assign rd_last = rd_ptr_q - AW'(1);
    assign rdata_o = empty_o ? mem_q[rd_last] : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues word reads to instruction memory, buffers the
// returned words with their PCs and hands them to the decoder over valid/ready.
//   clock_i, reset_i                 : clock, asynchronous active-high reset
//   imem_req_valid_o/ready_i/addr_o  : read request channel (word-aligned address)
//   imem_rsp_valid_i/data_i          : in-order read responses
//   redirect_valid_i/pc_i            : one-cycle restart of fetch at a new PC
//   out_valid_o/ready_i/inst_o/pc_o  : instruction stream to the decoder
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] buf_count, pend_count;
    logic [CW:0]   credit_sum;
    logic          req_fire, rsp_fire;
    logic          buf_push, buf_pop, buf_full, buf_empty;
    logic          pend_full, pend_empty;
    logic [31:0]   pend_pc;
    fetch_entry_t  buf_wdata, buf_rdata;

    // Every buffered word and every in-flight read (including ones that will be dropped)
    // holds a credit, so a returning word always finds a free buffer slot.
    assign credit_sum       = {1'b0, buf_count} + {1'b0, outstanding_q};
    assign imem_req_valid_o = !reset_i && !redirect_valid_i
                              && (credit_sum < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fire = imem_rsp_valid_i;

    assign buf_push = rsp_fire && (drop_q == '0) && !redirect_valid_i;
    assign buf_pop  = out_valid_o && out_ready_i;

    always_comb begin
        buf_wdata.inst = imem_rsp_data_i;
        buf_wdata.pc   = pend_pc;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_d        = drop_q;
        if (redirect_valid_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            // A response arriving now is dropped too, so it is not counted again.
            drop_d     = outstanding_q - CW'(rsp_fire);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // PCs of accepted requests, popped as their responses return. Never flushed: stale
    // responses still arrive and must stay paired with their own PCs.
    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .T     (logic [31:0])
    ) u_pend_q (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (req_fire),
        .pop_i   (rsp_fire),
        .flush_i (1'b0),
        .wdata_i (fetch_pc_q),
        .rdata_o (pend_pc),
        .count_o (pend_count),
        .full_o  (pend_full),
        .empty_o (pend_empty)
    );

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_buf (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (redirect_valid_i),
        .wdata_i (buf_wdata),
        .rdata_o (buf_rdata),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign out_valid_o = !buf_empty;
    assign out_inst_o  = buf_rdata.inst;
    assign out_pc_o    = buf_rdata.pc;

    a_buf_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
        buf_push |-> !buf_full);
    a_pend_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
        req_fire |-> !pend_full);
    a_rsp_was_requested: assert property (@(posedge clock_i) disable iff (reset_i)
        rsp_fire |-> !pend_empty);
    a_pend_tracks_outstanding: assert property (@(posedge clock_i) disable iff (reset_i)
        pend_count == outstanding_q);
    a_drop_bounded: assert property (@(posedge clock_i) disable iff (reset_i)
        drop_q <= outstanding_q);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV    = 32'h0040_0000;
    // Depth 4 lets a zero-wait memory keep one word per cycle flowing.
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    instruction_fetch_unit #(
        .RESET_VECTOR (RV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .redirect_valid_i (redir_valid),
        .redirect_pc_i    (redir_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_inst_o       (out_inst),
        .out_pc_o         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    int          n_req = 0;
    int          n0;
    logic        rsp_en;
    logic [31:0] exp_pc;
    logic [31:0] mq [$];

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, then update the memory model
    // and its response outputs 1 time unit after the edge.
    task automatic tick();
        logic        acc, took, popd;
        logic [31:0] aa;
        #1;
        acc  = req_valid && req_ready;
        aa   = req_addr;
        took = rsp_valid;
        popd = out_valid && out_ready;
        if (popd) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_inst", out_inst, mk(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_out++;
        end
        if (acc) begin
            chk("req_align", {30'd0, aa[1:0]}, 32'd0);
            n_req++;
        end
        @(posedge clk);
        #1;
        if (took && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(aa);
        rsp_valid = rsp_en && (mq.size() > 0);
        rsp_data  = rsp_valid ? mk(mq[0]) : 32'h0;
    endtask

    initial begin
        rst         = 1'b1;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = 32'h0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        out_ready   = 1'b0;
        rsp_en      = 1'b0;
        exp_pc      = RV;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_req_addr", req_addr, RV);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", {31'd0, req_valid}, 32'd1);
        chk("rel_req_addr", req_addr, RV);

        // 1: zero-wait memory, address sequence
        req_ready = 1'b1;
        rsp_en    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("addr_1", req_addr, 32'h0040_0004);
        tick();
        chk("addr_2", req_addr, 32'h0040_0008);

        // 3: memory stalls; address must hold
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {31'd0, req_valid}, 32'd1);
            chk("stall_addr", req_addr, 32'h0040_0008);
            tick();
        end

        // 1: sustained throughput
        req_ready = 1'b1;
        repeat (4) tick();
        n0 = n_out;
        repeat (8) tick();
        chk("sustain", n_out - n0, 32'd8);

        // Drain
        req_ready = 1'b0;
        repeat (4) tick();
        #1;
        chk("drained", {31'd0, out_valid}, 32'd0);

        // 2: consumer stalls; exactly DEPTH requests then back-pressure
        out_ready = 1'b0;
        req_ready = 1'b1;
        n0 = n_req;
        repeat (10) tick();
        #1;
        chk("full_req_count", n_req - n0, DEPTH);
        chk("full_req_valid", {31'd0, req_valid}, 32'd0);
        req_ready = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (10) tick();
        chk("full_out_count", n_out - n0, DEPTH);
        #1;
        chk("full_empty", {31'd0, out_valid}, 32'd0);

        // 4: redirect with two responses outstanding
        rsp_en    = 1'b0;
        req_ready = 1'b1;
        repeat (2) tick();
        chk("pre_redir_outstanding", mq.size(), 32'd2);
        redir_valid = 1'b1;
        redir_pc    = 32'h0040_0103;
        #1;
        chk("redir_no_req", {31'd0, req_valid}, 32'd0);
        tick();
        redir_valid = 1'b0;
        exp_pc      = 32'h0040_0100;
        rsp_en      = 1'b1;
        #1;
        chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_req_addr", req_addr, 32'h0040_0100);
        chk("redir_req_valid", {31'd0, req_valid}, 32'd1);
        n0 = n_out;
        repeat (10) tick();
        chk("redir_progress", {31'd0, (n_out > n0)}, 32'd1);

        // 5: redirect coinciding with a response and a consumer pop
        for (int i = 0; i < 4; i++) if (!rsp_valid) tick();
        redir_valid = 1'b1;
        redir_pc    = 32'h0050_0000;
        tick();
        redir_valid = 1'b0;
        exp_pc      = 32'h0050_0000;
        #1;
        chk("redir2_out_valid", {31'd0, out_valid}, 32'd0);
        n0 = n_out;
        repeat (10) tick();
        chk("redir2_progress", {31'd0, (n_out > n0)}, 32'd1);

        // 6: PC wrap, then reset mid-stream
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        exp_pc      = 32'hFFFF_FFFC;
        #1;
        chk("wrap_valid", {31'd0, req_valid}, 32'd1);
        chk("wrap_addr0", req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", req_addr, 32'h0000_0000);
        n0 = n_out;
        repeat (6) tick();
        chk("wrap_progress", {31'd0, (n_out > n0)}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("midrst_req_addr", req_addr, RV);
        mq.delete();
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        tick();
        rst    = 1'b0;
        exp_pc = RV;
        #1;
        chk("post_rst_valid", {31'd0, req_valid}, 32'd1);
        chk("post_rst_addr", req_addr, RV);
        n0 = n_out;
        repeat (8) tick();
        chk("post_rst_progress", {31'd0, (n_out > n0)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
